pipe_datapath: RTL

- Three-stage pipelined successor of the single-cycle reduced RISC-V datapath.
- Contains: register file, ALU with immediate mux, word-addressed data memory and writeback mux.
- Adds a valid-qualified issue port, full operand forwarding, and parametrised width, register count and memory depth.
- Sits under the control decoder; consumes already-decoded control fields, one instruction per cycle, no stalls.

---
 rtl/pipe_datapath_pkg.sv | 31 +++
 rtl/pipe_datapath_if.sv | 30 +++
 rtl/pipe_alu.sv | 40 ++++
 rtl/pipe_datapath.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pipe_datapath_pkg.sv
// rtl/pipe_datapath_pkg.sv - ALU encodings and pipeline register layouts
package pipe_datapath_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b111;

  // Control half of the ID/EX register; operand data lives beside it
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  result_src;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } idex_ctrl_t;

  // Control half of the EX/WB register
  typedef struct packed {
    logic valid;
    logic reg_write;
  } exwb_ctrl_t;

endpackage

// File: rtl/pipe_datapath_if.sv
// rtl/pipe_datapath_if.sv - decoded-instruction issue port and status outputs
interface pipe_datapath_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 3
);
  logic                     in_valid;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     RegWrite;
  logic                     MemWrite;
  logic                     ResultSrc;
  logic [ALUctrl_WIDTH-1:0] ALUctrl;
  logic                     ALUsrc;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     EQ;
  logic                     wb_valid;
  logic [DATA_WIDTH-1:0]    a0;

  modport master (
    output in_valid, ImmOp, RegWrite, MemWrite, ResultSrc, ALUctrl, ALUsrc, rs1, rs2, rd,
    input  EQ, wb_valid, a0
  );

  modport slave (
    input  in_valid, ImmOp, RegWrite, MemWrite, ResultSrc, ALUctrl, ALUsrc, rs1, rs2, rd,
    output EQ, wb_valid, a0
  );
endinterface

// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - EX-stage operand mux, ALU and raw equality compare
module pipe_alu
  import pipe_datapath_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUctrl_WIDTH = ALU_CTRL_W
) (
  input  logic [DATA_WIDTH-1:0]    op1_i,
  input  logic [DATA_WIDTH-1:0]    rs2v_i,
  input  logic [DATA_WIDTH-1:0]    imm_i,
  input  logic                     alu_src_i,
  input  logic [ALUctrl_WIDTH-1:0] alu_ctrl_i,
  output logic [DATA_WIDTH-1:0]    alu_out_o,
  output logic                     eq_o
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] op2;
  logic [SHW-1:0]        shamt;

  assign op2   = alu_src_i ? imm_i : rs2v_i;
  assign shamt = op2[SHW-1:0];
  assign eq_o  = (op1_i == rs2v_i);

  // Operation select; add/sub wrap naturally at DATA_WIDTH bits
  always_comb begin
    alu_out_o = '0;
    case (alu_ctrl_i)
      ALU_ADD: alu_out_o = op1_i + op2;
      ALU_SUB: alu_out_o = op1_i - op2;
      ALU_AND: alu_out_o = op1_i & op2;
      ALU_OR:  alu_out_o = op1_i | op2;
      ALU_XOR: alu_out_o = op1_i ^ op2;
      ALU_SLT: alu_out_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1_i) < $signed(op2))};
      ALU_SLL: alu_out_o = op1_i << shamt;
      ALU_SRL: alu_out_o = op1_i >> shamt;
      default: alu_out_o = op1_i + op2;
    endcase
  end
endmodule

// File: rtl/pipe_datapath.sv
// rtl/pipe_datapath.sv - three-stage issue/EX/WB datapath with full forwarding
module pipe_datapath
  import pipe_datapath_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = ALU_CTRL_W,
  parameter int DMEM_DEPTH    = 256,
  parameter int A0_INDEX      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_datapath_if.slave bus
);
  localparam int NREG   = 2 ** ADDRESS_WIDTH;
  localparam int MEM_AW = $clog2(DMEM_DEPTH);

  logic [DATA_WIDTH-1:0] rf_q   [NREG];
  logic [DATA_WIDTH-1:0] dmem_q [DMEM_DEPTH];

  idex_ctrl_t               idex_ctrl_q, idex_ctrl_d;
  logic [DATA_WIDTH-1:0]    idex_op1_q, idex_op1_d;
  logic [DATA_WIDTH-1:0]    idex_rs2v_q, idex_rs2v_d;
  logic [DATA_WIDTH-1:0]    idex_imm_q, idex_imm_d;
  logic [ADDRESS_WIDTH-1:0] idex_rd_q, idex_rd_d;

  exwb_ctrl_t               exwb_ctrl_q, exwb_ctrl_d;
  logic [DATA_WIDTH-1:0]    exwb_result_q, exwb_result_d;
  logic [ADDRESS_WIDTH-1:0] exwb_rd_q, exwb_rd_d;

  logic [DATA_WIDTH-1:0] alu_out, mem_rdata, ex_result;
  logic [MEM_AW-1:0]     ex_addr;
  logic                  alu_eq, ex_fwd_en, wb_fwd_en;

  pipe_alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ALUctrl_WIDTH(ALUctrl_WIDTH)
  ) u_alu (
    .op1_i     (idex_op1_q),
    .rs2v_i    (idex_rs2v_q),
    .imm_i     (idex_imm_q),
    .alu_src_i (idex_ctrl_q.alu_src),
    .alu_ctrl_i(idex_ctrl_q.alu_ctrl),
    .alu_out_o (alu_out),
    .eq_o      (alu_eq)
  );

  // Byte address drops its low two bits and anything above the memory depth
  assign ex_addr   = alu_out[MEM_AW+1:2];
  assign mem_rdata = dmem_q[ex_addr];
  assign ex_result = idex_ctrl_q.result_src ? mem_rdata : alu_out;

  assign ex_fwd_en = idex_ctrl_q.valid & idex_ctrl_q.reg_write;
  assign wb_fwd_en = exwb_ctrl_q.valid & exwb_ctrl_q.reg_write;

  // Operand read: x0 is zero, then youngest in-flight producer wins, then regfile
  always_comb begin
    idex_op1_d = rf_q[bus.rs1];
    if (bus.rs1 == '0)                                 idex_op1_d = '0;
    else if (ex_fwd_en && (idex_rd_q == bus.rs1))      idex_op1_d = ex_result;
    else if (wb_fwd_en && (exwb_rd_q == bus.rs1))      idex_op1_d = exwb_result_q;
    idex_rs2v_d = rf_q[bus.rs2];
    if (bus.rs2 == '0)                                 idex_rs2v_d = '0;
    else if (ex_fwd_en && (idex_rd_q == bus.rs2))      idex_rs2v_d = ex_result;
    else if (wb_fwd_en && (exwb_rd_q == bus.rs2))      idex_rs2v_d = exwb_result_q;
  end

  // Next-state of both pipeline registers; a bubble only clears valid
  always_comb begin
    idex_ctrl_d = '{valid: bus.in_valid, reg_write: bus.RegWrite, mem_write: bus.MemWrite,
                    result_src: bus.ResultSrc, alu_src: bus.ALUsrc, alu_ctrl: bus.ALUctrl};
    idex_imm_d    = bus.ImmOp;
    idex_rd_d     = bus.rd;
    exwb_ctrl_d   = '{valid: idex_ctrl_q.valid, reg_write: idex_ctrl_q.reg_write};
    exwb_result_d = ex_result;
    exwb_rd_d     = idex_rd_q;
  end

  // Pipeline registers; reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q   <= '0;
      idex_op1_q    <= '0;
      idex_rs2v_q   <= '0;
      idex_imm_q    <= '0;
      idex_rd_q     <= '0;
      exwb_ctrl_q   <= '0;
      exwb_result_q <= '0;
      exwb_rd_q     <= '0;
    end else begin
      idex_ctrl_q   <= idex_ctrl_d;
      idex_op1_q    <= idex_op1_d;
      idex_rs2v_q   <= idex_rs2v_d;
      idex_imm_q    <= idex_imm_d;
      idex_rd_q     <= idex_rd_d;
      exwb_ctrl_q   <= exwb_ctrl_d;
      exwb_result_q <= exwb_result_d;
      exwb_rd_q     <= exwb_rd_d;
    end
  end

  // Register file commit at the edge leaving WB; x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_fwd_en && (exwb_rd_q != '0)) begin
      rf_q[exwb_rd_q] <= exwb_result_q;
    end
  end

  // Store at the edge leaving EX; contents survive reset, but a store racing reset is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (idex_ctrl_q.valid && idex_ctrl_q.mem_write) begin
      dmem_q[ex_addr] <= idex_rs2v_q;
    end
  end

  assign bus.EQ       = idex_ctrl_q.valid & alu_eq;
  assign bus.wb_valid = exwb_ctrl_q.valid;
  assign bus.a0       = rf_q[A0_INDEX];
endmodule
